// File: rtl/mmu_pool_pkg.sv
// Shared types and constants for the MMU page pool.
// Fail-reason codes are reported on both the alloc and free response channels.
package mmu_pool_pkg;

    localparam int unsigned FAIL_REASON_WIDTH = 2;

    typedef logic [FAIL_REASON_WIDTH-1:0] fail_reason_t;

    localparam fail_reason_t FAIL_NONE         = 2'd0;
    localparam fail_reason_t FAIL_POOL_EMPTY   = 2'd1;
    localparam fail_reason_t FAIL_OUT_OF_RANGE = 2'd2;
    localparam fail_reason_t FAIL_DOUBLE_FREE  = 2'd3;

    typedef enum logic {
        StInit,
        StRun
    } pool_state_e;

endpackage

// File: rtl/mmu_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with 1-cycle latency.
// Holds the circular free list of page indices.
module mmu_sdp_ram #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned WIDTH      = 3,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/mmu_page_pool.sv
// Page allocator: hands out 4K page indices from a FIFO free list and accepts them back,
// rejecting empty-pool allocs, out-of-range frees and frees of pages not currently allocated.
module mmu_page_pool
    import mmu_pool_pkg::*;
#(
    parameter int unsigned PAGE_COUNT = 4096,
    parameter int unsigned ID_WIDTH   = 8,
    localparam int unsigned IDX_WIDTH = (PAGE_COUNT > 2) ? $clog2(PAGE_COUNT) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_req_valid,
    output logic                         alloc_req_ready,
    input  logic [ID_WIDTH-1:0]          alloc_req_id,
    input  logic                         free_req_valid,
    output logic                         free_req_ready,
    input  logic [ID_WIDTH-1:0]          free_req_id,
    input  logic [IDX_WIDTH:0]           free_req_page_idx,
    output logic                         alloc_rsp_valid,
    output logic [ID_WIDTH-1:0]          alloc_rsp_id,
    output logic [IDX_WIDTH-1:0]         alloc_rsp_page_idx,
    output logic                         alloc_rsp_fail,
    output logic [FAIL_REASON_WIDTH-1:0] alloc_rsp_fail_reason,
    output logic                         free_rsp_valid,
    output logic [ID_WIDTH-1:0]          free_rsp_id,
    output logic                         free_rsp_fail,
    output logic [FAIL_REASON_WIDTH-1:0] free_rsp_fail_reason,
    output logic                         init_done,
    output logic [IDX_WIDTH:0]           free_count
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX   = IDX_WIDTH'(PAGE_COUNT - 1);
    localparam logic [IDX_WIDTH:0]   COUNT_FULL = (IDX_WIDTH + 1)'(PAGE_COUNT);

    function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] p);
        return (p == LAST_IDX) ? '0 : p + IDX_WIDTH'(1);
    endfunction

    pool_state_e            state_q, state_d;
    logic [IDX_WIDTH-1:0]   init_cnt_q, rd_ptr_q, wr_ptr_q;
    logic [IDX_WIDTH:0]     free_count_q;
    logic [PAGE_COUNT-1:0]  alloc_map_q, alloc_map_d;

    logic                   alloc_rsp_valid_q, alloc_rsp_fail_q, free_rsp_valid_q, free_rsp_fail_q;
    logic [ID_WIDTH-1:0]    alloc_rsp_id_q, free_rsp_id_q;
    fail_reason_t           alloc_rsp_reason_q, free_rsp_reason_q, free_reason;

    logic                   run, alloc_fire, free_fire, pool_empty, pop, push;
    logic                   pending_valid, free_in_range, free_is_alloc;
    logic [IDX_WIDTH-1:0]   free_idx, ram_rd_data, ram_wr_addr, ram_wr_data;

    always_comb begin
        state_d = state_q;
        if (state_q == StInit && init_cnt_q == LAST_IDX) begin
            state_d = StRun;
        end
    end

    assign run        = (state_q == StRun);
    assign alloc_fire = alloc_req_valid && run;
    assign free_fire  = free_req_valid && run;
    assign pool_empty = (free_count_q == '0);
    assign pop        = alloc_fire && !pool_empty;

    // The page popped last cycle is only visible now on the RAM output; treat it as
    // allocated so it can be freed in its response cycle before the bitmap catches up.
    assign pending_valid = alloc_rsp_valid_q && !alloc_rsp_fail_q;
    assign free_idx      = free_req_page_idx[IDX_WIDTH-1:0];
    assign free_in_range = (free_req_page_idx < COUNT_FULL);
    assign free_is_alloc = free_in_range &&
                           (alloc_map_q[free_idx] || (pending_valid && ram_rd_data == free_idx));
    assign push          = free_fire && free_is_alloc;

    always_comb begin
        free_reason = FAIL_NONE;
        if (!free_in_range) begin
            free_reason = FAIL_OUT_OF_RANGE;
        end else if (!free_is_alloc) begin
            free_reason = FAIL_DOUBLE_FREE;
        end
    end

    always_comb begin
        alloc_map_d = alloc_map_q;
        if (pending_valid) begin
            alloc_map_d[ram_rd_data] = 1'b1;
        end
        if (push) begin
            alloc_map_d[free_idx] = 1'b0;
        end
    end

    assign ram_wr_addr = run ? wr_ptr_q : init_cnt_q;
    assign ram_wr_data = run ? free_idx : init_cnt_q;

    mmu_sdp_ram #(
        .DEPTH      (PAGE_COUNT),
        .WIDTH      (IDX_WIDTH),
        .ADDR_WIDTH (IDX_WIDTH)
    ) u_free_list (
        .clk     (clk),
        .wr_en   (!run || push),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_en   (pop),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= StInit;
            init_cnt_q         <= '0;
            rd_ptr_q           <= '0;
            wr_ptr_q           <= '0;
            free_count_q       <= '0;
            alloc_map_q        <= '0;
            alloc_rsp_valid_q  <= 1'b0;
            alloc_rsp_id_q     <= '0;
            alloc_rsp_fail_q   <= 1'b0;
            alloc_rsp_reason_q <= FAIL_NONE;
            free_rsp_valid_q   <= 1'b0;
            free_rsp_id_q      <= '0;
            free_rsp_fail_q    <= 1'b0;
            free_rsp_reason_q  <= FAIL_NONE;
        end else begin
            state_q     <= state_d;
            alloc_map_q <= alloc_map_d;
            if (!run) begin
                init_cnt_q <= wrap_inc(init_cnt_q);
                if (state_d == StRun) begin
                    free_count_q <= COUNT_FULL;
                end
            end else begin
                if (pop) begin
                    rd_ptr_q <= wrap_inc(rd_ptr_q);
                end
                if (push) begin
                    wr_ptr_q <= wrap_inc(wr_ptr_q);
                end
                free_count_q <= free_count_q + (IDX_WIDTH + 1)'(push) - (IDX_WIDTH + 1)'(pop);
            end
            alloc_rsp_valid_q  <= alloc_fire;
            alloc_rsp_fail_q   <= alloc_fire && pool_empty;
            alloc_rsp_reason_q <= (alloc_fire && pool_empty) ? FAIL_POOL_EMPTY : FAIL_NONE;
            free_rsp_valid_q   <= free_fire;
            free_rsp_fail_q    <= free_fire && (free_reason != FAIL_NONE);
            free_rsp_reason_q  <= free_fire ? free_reason : FAIL_NONE;
            if (alloc_fire) begin
                alloc_rsp_id_q <= alloc_req_id;
            end
            if (free_fire) begin
                free_rsp_id_q <= free_req_id;
            end
        end
    end

    assign alloc_req_ready       = run;
    assign free_req_ready        = run;
    assign init_done             = run;
    assign free_count            = free_count_q;
    assign alloc_rsp_valid       = alloc_rsp_valid_q;
    assign alloc_rsp_id          = alloc_rsp_id_q;
    assign alloc_rsp_page_idx    = pending_valid ? ram_rd_data : '0;
    assign alloc_rsp_fail        = alloc_rsp_fail_q;
    assign alloc_rsp_fail_reason = alloc_rsp_reason_q;
    assign free_rsp_valid        = free_rsp_valid_q;
    assign free_rsp_id           = free_rsp_id_q;
    assign free_rsp_fail         = free_rsp_fail_q;
    assign free_rsp_fail_reason  = free_rsp_reason_q;

endmodule

// File: tb/tb_mmu_page_pool.sv
// Scoreboard bench for mmu_page_pool: directed scenarios on an 8-page pool plus a
// mixed alloc/free run on a 6-page pool checked against a FIFO reference model.
module tb_mmu_page_pool;

    typedef struct {
        int id;
        int fail;
        int reason;
        int idx;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    exp_t qa8[$], qf8[$], qa6[$], qf6[$];

    // 8-page instance
    logic       a8_v = 0, f8_v = 0, a8_ready, f8_ready, done8;
    logic [3:0] a8_id = 0, f8_id = 0, f8_idx = 0, fc8;
    logic       a8_rv, a8_rfail, f8_rv, f8_rfail;
    logic [3:0] a8_rid, f8_rid;
    logic [2:0] a8_ridx;
    logic [1:0] a8_rreason, f8_rreason;

    // 6-page instance
    logic       a6_v = 0, f6_v = 0, a6_ready, f6_ready, done6;
    logic [3:0] a6_id = 0, f6_id = 0, f6_idx = 0, fc6;
    logic       a6_rv, a6_rfail, f6_rv, f6_rfail;
    logic [3:0] a6_rid, f6_rid;
    logic [2:0] a6_ridx;
    logic [1:0] a6_rreason, f6_rreason;

    mmu_page_pool #(.PAGE_COUNT(8), .ID_WIDTH(4)) dut8 (
        .clk(clk), .rst(rst),
        .alloc_req_valid(a8_v), .alloc_req_ready(a8_ready), .alloc_req_id(a8_id),
        .free_req_valid(f8_v), .free_req_ready(f8_ready), .free_req_id(f8_id),
        .free_req_page_idx(f8_idx),
        .alloc_rsp_valid(a8_rv), .alloc_rsp_id(a8_rid), .alloc_rsp_page_idx(a8_ridx),
        .alloc_rsp_fail(a8_rfail), .alloc_rsp_fail_reason(a8_rreason),
        .free_rsp_valid(f8_rv), .free_rsp_id(f8_rid), .free_rsp_fail(f8_rfail),
        .free_rsp_fail_reason(f8_rreason),
        .init_done(done8), .free_count(fc8)
    );

    mmu_page_pool #(.PAGE_COUNT(6), .ID_WIDTH(4)) dut6 (
        .clk(clk), .rst(rst),
        .alloc_req_valid(a6_v), .alloc_req_ready(a6_ready), .alloc_req_id(a6_id),
        .free_req_valid(f6_v), .free_req_ready(f6_ready), .free_req_id(f6_id),
        .free_req_page_idx(f6_idx),
        .alloc_rsp_valid(a6_rv), .alloc_rsp_id(a6_rid), .alloc_rsp_page_idx(a6_ridx),
        .alloc_rsp_fail(a6_rfail), .alloc_rsp_fail_reason(a6_rreason),
        .free_rsp_valid(f6_rv), .free_rsp_id(f6_rid), .free_rsp_fail(f6_rfail),
        .free_rsp_fail_reason(f6_rreason),
        .init_done(done6), .free_count(fc6)
    );

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    task automatic cmp_rsp(input string name, input exp_t e, input int id, input int fail,
                           input int reason, input int idx);
        checks++;
        if (e.id != id || e.fail != fail || e.reason != reason || e.idx != idx || e.due != cyc)
        begin
            errors++;
            $display("FAIL %s: got id=%0d fail=%0d reason=%0d idx=%0d cyc=%0d, want id=%0d fail=%0d reason=%0d idx=%0d cyc=%0d",
                     name, id, fail, reason, idx, cyc, e.id, e.fail, e.reason, e.idx, e.due);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got response with empty scoreboard, want none", name);
    endtask

    // Monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clk) begin
        exp_t e;
        if (a8_rv) begin
            if (qa8.size() == 0) unexpected("alloc8");
            else begin e = qa8.pop_front(); cmp_rsp("alloc8", e, a8_rid, a8_rfail, a8_rreason, a8_ridx); end
        end
        if (f8_rv) begin
            if (qf8.size() == 0) unexpected("free8");
            else begin e = qf8.pop_front(); cmp_rsp("free8", e, f8_rid, f8_rfail, f8_rreason, 0); end
        end
        if (a6_rv) begin
            if (qa6.size() == 0) unexpected("alloc6");
            else begin e = qa6.pop_front(); cmp_rsp("alloc6", e, a6_rid, a6_rfail, a6_rreason, a6_ridx); end
        end
        if (f6_rv) begin
            if (qf6.size() == 0) unexpected("free6");
            else begin e = qf6.pop_front(); cmp_rsp("free6", e, f6_rid, f6_rfail, f6_rreason, 0); end
        end
    end

    function automatic int outs8();
        return int'({a8_rv, a8_rid, a8_ridx, a8_rfail, a8_rreason, f8_rv, f8_rid, f8_rfail,
                     f8_rreason, done8, fc8, a8_ready, f8_ready});
    endfunction

    function automatic void ea8(input int id, input int fail, input int reason, input int idx);
        qa8.push_back('{id, fail, reason, idx, cyc + 1});
    endfunction

    function automatic void ef8(input int id, input int fail, input int reason);
        qf8.push_back('{id, fail, reason, 0, cyc + 1});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input bit a, input int aid, input bit f, input int fid, input int fidx);
        a8_v = a; a8_id = 4'(aid); f8_v = f; f8_id = 4'(fid); f8_idx = 4'(fidx);
        step();
        a8_v = 0; f8_v = 0;
    endtask

    task automatic reset_init(input string tag);
        int n;
        rst = 1;
        qa8.delete(); qf8.delete(); qa6.delete(); qf6.delete();
        #1;
        chk({tag, "_rst_outputs"}, outs8(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 1) chk({tag, "_init_ready_low"}, int'({a8_ready, f8_ready}), 0);
            if (done8) begin n = i; break; end
        end
        chk({tag, "_init_cycles"}, n, 8);
        chk({tag, "_init_free_count"}, fc8, 8);
    endtask

    task automatic alloc_all8(input string tag);
        for (int i = 0; i < 8; i++) begin
            ea8(i, 0, 0, i);
            drive8(1, i, 0, 0, 0);
        end
        step();
        chk({tag, "_drained_count"}, fc8, 0);
    endtask

    // Reference model state for the 6-page instance.
    int  pool6[$];
    bit  map6[8];
    logic [31:0] lf = 32'h1234_5678;

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_init("boot");

        // Nine back-to-back allocs: pages 0..7, then empty-pool failure.
        for (int i = 0; i < 9; i++) begin
            if (i < 8) ea8(i, 0, 0, i);
            else ea8(i, 1, 1, 0);
            drive8(1, i, 0, 0, 0);
        end
        chk("empty_free_count", fc8, 0);

        ef8(9, 0, 0);  drive8(0, 0, 1, 9, 3);
        ea8(10, 0, 0, 3); drive8(1, 10, 0, 0, 0);
        ef8(11, 0, 0); drive8(0, 0, 1, 11, 3);    // free in the alloc's response cycle
        ef8(12, 1, 3); drive8(0, 0, 1, 12, 3);
        ef8(13, 1, 2); drive8(0, 0, 1, 13, 8);
        chk("after_frees_count", fc8, 1);

        ea8(14, 0, 0, 3); drive8(1, 14, 0, 0, 0);
        chk("empty_again_count", fc8, 0);
        ea8(15, 1, 1, 0); ef8(4, 0, 0); drive8(1, 15, 1, 4, 5);
        chk("same_cycle_count", fc8, 1);
        ea8(1, 0, 0, 5); ef8(2, 1, 3); drive8(1, 1, 1, 2, 5);
        chk("same_page_count", fc8, 0);
        step(); step();

        // Reset mid-INIT, then reset during RUN with a response in flight.
        rst = 1; step(); rst = 0;
        repeat (3) step();
        reset_init("mid_init");
        alloc_all8("mid_init");
        ea8(7, 1, 1, 0); drive8(1, 7, 0, 0, 0);
        reset_init("mid_run");
        alloc_all8("mid_run");

        // Mixed traffic on the 6-page pool against the FIFO model.
        pool6.delete();
        for (int p = 0; p < 6; p++) begin pool6.push_back(p); map6[p] = 0; end
        map6[6] = 0; map6[7] = 0;
        chk("dut6_ready", int'(done6), 1);
        for (int c = 0; c < 200; c++) begin
            bit a, f, fok;
            int fidx, apage, start;
            lf = lf ^ (lf << 13); lf = lf ^ (lf >> 17); lf = lf ^ (lf << 5);
            a = lf[0] | lf[1];
            f = lf[2] | lf[3];
            fidx = int'(lf[10:8]);
            if (lf[7:6] != 0) begin
                start = int'(lf[14:12]) % 6;
                for (int k = 0; k < 6; k++)
                    if (map6[(start + k) % 6]) begin fidx = (start + k) % 6; break; end
            end
            fok = (fidx < 6) && map6[fidx];
            if (f) qf6.push_back('{(c + 8) % 16, fok ? 0 : 1, (fidx >= 6) ? 2 : (fok ? 0 : 3), 0, cyc + 1});
            apage = -1;
            if (a) begin
                if (pool6.size() > 0) begin
                    apage = pool6.pop_front();
                    qa6.push_back('{c % 16, 0, 0, apage, cyc + 1});
                end else begin
                    qa6.push_back('{c % 16, 1, 1, 0, cyc + 1});
                end
            end
            if (apage >= 0) map6[apage] = 1;
            if (f && fok) begin map6[fidx] = 0; pool6.push_back(fidx); end
            a6_v = a; a6_id = 4'(c % 16); f6_v = f; f6_id = 4'((c + 8) % 16); f6_idx = 4'(fidx);
            step();
            chk("free_count6", fc6, pool6.size());
        end
        a6_v = 0; f6_v = 0;
        step(); step();

        chk("alloc8_queue_drained", qa8.size(), 0);
        chk("free8_queue_drained", qf8.size(), 0);
        chk("alloc6_queue_drained", qa6.size(), 0);
        chk("free6_queue_drained", qf6.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmu_page_pool.md
MMU_PAGE_POOL -- requirements
Module: mmu_page_pool

Interface
REQ-001 SHALL have parameter PAGE_COUNT, default 4096, number of managed 4K pages (2..65536).
REQ-002 SHALL have parameter ID_WIDTH, default 8, request/response tag width.
REQ-003 SHALL derive localparam IDX_WIDTH = clog2(PAGE_COUNT), minimum 1.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports alloc_req_valid in 1, alloc_req_ready out 1, alloc_req_id in ID_WIDTH: allocate one page.
REQ-007 SHALL have ports free_req_valid in 1, free_req_ready out 1, free_req_id in ID_WIDTH, free_req_page_idx in IDX_WIDTH+1: return one page.
REQ-008 SHALL have ports alloc_rsp_valid out 1, alloc_rsp_id out ID_WIDTH, alloc_rsp_page_idx out IDX_WIDTH, alloc_rsp_fail out 1, alloc_rsp_fail_reason out 2.
REQ-009 SHALL have ports free_rsp_valid out 1, free_rsp_id out ID_WIDTH, free_rsp_fail out 1, free_rsp_fail_reason out 2.
REQ-010 SHALL have ports init_done out 1 and free_count out IDX_WIDTH+1 (pages currently in pool).

Function
REQ-011 SHALL implement FSM states INIT and RUN; reset enters INIT.
REQ-012 In INIT, SHALL write index k into free-list slot k for k = 0..PAGE_COUNT-1, one per cycle, then enter RUN; init takes exactly PAGE_COUNT cycles.
REQ-013 SHALL hold alloc_req_ready, free_req_ready and init_done low in INIT; all three high in RUN.
REQ-014 Request accepted when valid && ready on a rising edge; one alloc and one free accepted in the same cycle.
REQ-015 Each accepted request SHALL yield exactly one response, rsp_valid high for one cycle, exactly 1 cycle after acceptance, id echoed; no response backpressure.
REQ-016 Alloc with free_count > 0: pop head of the circular free list, mark page allocated, fail=0, reason=0.
REQ-017 Alloc with free_count == 0: fail=1, reason=1 (POOL_EMPTY), page_idx=0, no state change.
REQ-018 Free with page_idx >= PAGE_COUNT: fail=1, reason=2 (OUT_OF_RANGE), no state change.
REQ-019 Free of page not marked allocated (per-page bitmap): fail=1, reason=3 (DOUBLE_FREE), no state change.
REQ-020 Valid free: push to tail, clear bitmap bit, fail=0, reason=0.
REQ-021 Simultaneous alloc+free: alloc evaluated against free_count before the free; a page freed this cycle not allocatable this cycle; free_count += push - pop.
REQ-022 Same-cycle alloc of page P and free of P: free sees pre-cycle bitmap (P not allocated) -> DOUBLE_FREE.
REQ-023 Read/write pointers SHALL wrap from PAGE_COUNT-1 to 0 for non-power-of-2 PAGE_COUNT; pool can never overflow.
REQ-024 Allocation order SHALL be FIFO: freed pages reissued after all pages already in pool.

Reset
REQ-025 On rst: FSM=INIT, init counter=0, pointers=0, free_count=0, bitmap all allocated-clear, all rsp_valid/fail/reason/id/idx outputs 0, init_done=0.
REQ-026 rst asserted mid-operation or mid-INIT SHALL discard in-flight responses and restart full INIT after release.

Structure
REQ-027 Package mmu_pool_pkg SHALL hold fail-reason constants (NONE=0, POOL_EMPTY=1, OUT_OF_RANGE=2, DOUBLE_FREE=3) and FAIL_REASON_WIDTH=2.
REQ-028 Free list SHALL be sub-module mmu_sdp_ram (simple dual-port, 1 write port, 1 synchronous read port, 1-cycle read latency), depth PAGE_COUNT, width IDX_WIDTH.
REQ-029 Bitmap and counters SHALL live in mmu_page_pool; no backdoor initialisation required.

Verification (PAGE_COUNT=8, ID_WIDTH=4)
REQ-030 Release rst -> init_done rises exactly 8 cycles later, free_count=8.
REQ-031 9 back-to-back allocs ids 0..8 -> pages 0..7 fail=0; id 8 fail=1 reason=1; free_count=0.
REQ-032 After 031, free page 3 then alloc -> free rsp ok, alloc returns page 3; free page 3 twice -> second reason=3; free idx 8 -> reason=2.
REQ-033 With free_count=0, same-cycle alloc+free page 5 -> alloc fail reason=1, free ok, free_count=1.
REQ-034 Mixed alloc/free 200 cycles with pointer wrap, PAGE_COUNT=6 -> responses match reference model, free_count consistent.
REQ-035 Assert rst during INIT and during RUN -> outputs zero immediately, full 8-cycle INIT repeats, pages 0..7 reissued in order.
